// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the pipeline controller and its
// multiply/divide occupancy timer.
package pipe_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // Latencies outside 2..15 would either never finish or overflow the 4-bit counter.
    function automatic logic [3:0] lat_clamp(input int lat);
        if (lat < 2) begin
            return 4'd2;
        end else if (lat > 15) begin
            return 4'd15;
        end else begin
            return 4'(lat);
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs between the
// five-stage datapath (master) and the stall controller (slave).
interface pipe_ctrl_if;

    logic       D_data_hazard;
    logic       D_md_use;
    logic       E_md_start;
    logic [1:0] E_md_op;
    logic       M_mem_wait;

    logic       PC_WE;
    logic       D_WE;
    logic       E_WE;
    logic       M_WE;
    logic       W_WE;
    logic       E_clr;
    logic       W_clr;
    logic       md_busy;
    logic       md_done;

    modport master (
        output D_data_hazard, D_md_use, E_md_start, E_md_op, M_mem_wait,
        input  PC_WE, D_WE, E_WE, M_WE, W_WE, E_clr, W_clr, md_busy, md_done
    );

    modport slave (
        input  D_data_hazard, D_md_use, E_md_start, E_md_op, M_mem_wait,
        output PC_WE, D_WE, E_WE, M_WE, W_WE, E_clr, W_clr, md_busy, md_done
    );

endinterface

// File: rtl/md_timer.sv
// Multiply/divide unit occupancy timer: IDLE/MULT/DIV state machine with a
// 4-bit down-counter that models the fixed MDU latency.
module md_timer
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       mem_wait,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] MULT_CNT = lat_clamp(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = lat_clamp(DIV_LAT);

    md_state_t  state_r;
    md_state_t  state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       accept_s;
    logic       done_s;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, counter load/decrement and start acceptance.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A start stalled by memory stays in E and retries after release.
                if (start && !mem_wait) begin
                    accept_s = 1'b1;
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_nxt_s = ST_MULT;
                            cnt_nxt_s   = MULT_CNT;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt_s = ST_DIV;
                            cnt_nxt_s   = DIV_CNT;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 4'd0;
                        end
                    endcase
                end else begin
                    cnt_nxt_s = 4'd0;
                end
            end
            ST_MULT, ST_DIV: begin
                // Counting continues through memory stalls; <= also recovers a corrupted zero.
                if (cnt_r <= 4'd1) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    assign busy = !reset && ((state_r != ST_IDLE) || accept_s);
    assign done = !reset && done_s;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges decode hazards, MDU occupancy and
// data-memory wait into PC/stage write enables and bubble inserts.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    logic md_busy_s;
    logic md_done_s;
    logic md_stall_s;
    logic d_stall_s;

    md_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (bus.E_md_start),
        .op       (bus.E_md_op),
        .mem_wait (bus.M_mem_wait),
        .busy     (md_busy_s),
        .done     (md_done_s)
    );

    assign md_stall_s  = bus.D_md_use && md_busy_s;
    assign d_stall_s   = bus.D_data_hazard || md_stall_s;
    assign bus.md_busy = md_busy_s;
    assign bus.md_done = md_done_s;

    // Stall priority: memory wait freezes everything but W, decode stall bubbles E.
    always_comb begin
        bus.PC_WE = 1'b1;
        bus.D_WE  = 1'b1;
        bus.E_WE  = 1'b1;
        bus.M_WE  = 1'b1;
        bus.W_WE  = 1'b1;
        bus.E_clr = 1'b0;
        bus.W_clr = 1'b0;
        if (bus.M_mem_wait) begin
            bus.PC_WE = 1'b0;
            bus.D_WE  = 1'b0;
            bus.E_WE  = 1'b0;
            bus.M_WE  = 1'b0;
            bus.W_clr = 1'b1;
        end else if (d_stall_s) begin
            bus.PC_WE = 1'b0;
            bus.D_WE  = 1'b0;
            bus.E_clr = 1'b1;
        end else begin
            bus.PC_WE = 1'b1;
            bus.D_WE  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a stall-priority vector table plus
// hand-written MULT, DIVU, memory-wait and reset-abort sequences.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // {PC_WE, D_WE, E_WE, M_WE, W_WE, E_clr, W_clr, md_busy}
    logic [7:0] obs;
    assign obs = {bus.PC_WE, bus.D_WE, bus.E_WE, bus.M_WE, bus.W_WE,
                  bus.E_clr, bus.W_clr, bus.md_busy};

    typedef struct {
        logic       haz;
        logic       md_use;
        logic       mw;
        logic       st;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b required %b", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic haz, input logic md_use, input logic st,
                         input logic [1:0] op, input logic mw);
        bus.D_data_hazard = haz;
        bus.D_md_use      = md_use;
        bus.E_md_start    = st;
        bus.E_md_op       = op;
        bus.M_mem_wait    = mw;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e;

        tbl[0] = '{haz: 1'b0, md_use: 1'b0, mw: 1'b0, st: 1'b0, exp: 8'b11111_0_0_0};
        tbl[1] = '{haz: 1'b1, md_use: 1'b0, mw: 1'b0, st: 1'b0, exp: 8'b00111_1_0_0};
        tbl[2] = '{haz: 1'b0, md_use: 1'b1, mw: 1'b0, st: 1'b0, exp: 8'b11111_0_0_0};
        tbl[3] = '{haz: 1'b0, md_use: 1'b0, mw: 1'b1, st: 1'b0, exp: 8'b00001_0_1_0};
        tbl[4] = '{haz: 1'b1, md_use: 1'b0, mw: 1'b1, st: 1'b0, exp: 8'b00001_0_1_0};
        tbl[5] = '{haz: 1'b0, md_use: 1'b1, mw: 1'b1, st: 1'b1, exp: 8'b00001_0_1_0};
        tbl[6] = '{haz: 1'b1, md_use: 1'b1, mw: 1'b0, st: 1'b0, exp: 8'b00111_1_0_0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        next_cycle();
        // Reset state: a start request under reset must not show busy.
        drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        chk("reset_outputs", 0, obs, 8'b11111_0_0_0);
        chk("reset_done", 0, {7'd0, bus.md_done}, 8'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        next_cycle();

        // Stall-priority table with the MDU idle.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].haz, tbl[i].md_use, tbl[i].st, 2'd0, tbl[i].mw);
            @(negedge clk);
            chk("table", i, obs, tbl[i].exp);
            chk("table_done", i, {7'd0, bus.md_done}, 8'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        next_cycle();

        // mult at cycle 0: busy 0..5, done at 5, idle at 6.
        for (int c = 0; c <= 6; c++) begin
            drive(1'b0, 1'b0, (c == 0), 2'd0, 1'b0);
            @(negedge clk);
            chk("mult_busy_done", c, {6'd0, bus.md_busy, bus.md_done},
                {6'd0, (c <= 5), (c == 5)});
            next_cycle();
        end

        // divu at cycle 0, D_md_use from cycle 2: stalled 2..10, released at 11.
        for (int c = 0; c <= 11; c++) begin
            drive(1'b0, (c >= 2), (c == 0), 2'd3, 1'b0);
            @(negedge clk);
            if (c >= 2 && c <= 10) begin
                e = 8'b00111_1_0_1;
            end else if (c <= 1) begin
                e = 8'b11111_0_0_1;
            end else begin
                e = 8'b11111_0_0_0;
            end
            chk("divu_stall", c, obs, e);
            chk("divu_done", c, {7'd0, bus.md_done}, {7'd0, (c == 10)});
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        next_cycle();

        // Start held off by memory wait for 3 cycles, accepted on cycle 3.
        for (int c = 0; c <= 9; c++) begin
            drive(1'b0, 1'b0, (c <= 3), 2'd1, (c <= 2));
            @(negedge clk);
            if (c <= 2) begin
                e = 8'b00001_0_1_0;
            end else if (c <= 8) begin
                e = 8'b11111_0_0_1;
            end else begin
                e = 8'b11111_0_0_0;
            end
            chk("memwait_start", c, obs, e);
            chk("memwait_done", c, {7'd0, bus.md_done}, {7'd0, (c == 8)});
            next_cycle();
        end

        // div started at cycle 0, reset at cycle 4: aborted with no done pulse.
        for (int c = 0; c <= 15; c++) begin
            reset = (c == 4);
            drive(1'b0, 1'b0, (c == 0), 2'd2, 1'b0);
            @(negedge clk);
            chk("div_abort", c, {6'd0, bus.md_busy, bus.md_done},
                {6'd0, (c <= 3), 1'b0});
            next_cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
